// File: rtl/fetch_if.sv
// ----------------------------------------------------------------------------
// fetch_if
//   Valid/ready handshake from the fetch queue to decode.
//   master (fetch queue): drives valid, instr, op, imm, pc, illegal; samples ready
//   slave  (decode)     : samples the head fields; drives ready (execute !mult)
// ----------------------------------------------------------------------------
interface fetch_if;
  logic        valid;    // queue head holds an instruction
  logic        ready;    // decode accepts the head this cycle
  logic [31:0] instr;    // head instruction word
  logic [7:0]  op;       // instr[7:0]
  logic [23:0] imm;      // instr[31:8]
  logic [31:0] pc;       // unwrapped PC of the head instruction
  logic        illegal;  // head op above the last defined ALU op

  modport master (output valid, instr, op, imm, pc, illegal, input  ready);
  modport slave  (input  valid, instr, op, imm, pc, illegal, output ready);
endinterface

// File: rtl/pipeline_fetch_queue.sv
// ----------------------------------------------------------------------------
// pipeline_fetch_queue
//   Instruction fetch + prefetch FIFO in front of the accumulator execute pipe.
//   Holds the instruction memory and a sequential fetch PC, prefetches words
//   into a small circular queue and presents the head to decode. Back-pressure
//   from decode stalls fetch; a redirect flushes and restarts at a new PC.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   i_imem_we       instruction memory write enable (program load)
//   i_imem_waddr    memory write address
//   i_imem_wdata    memory write data (op [7:0], imm [31:8])
//   i_redir_valid   flush the queue and restart fetch at i_redir_pc
//   i_redir_pc      redirect target PC
//   o_dec           fetch_if.master handshake towards decode
//   o_q_count       queue occupancy
//   o_pop_count     completed handshakes since reset (wraps at 2^32)
// ----------------------------------------------------------------------------
module pipeline_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int IMEM_WORDS = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] i_imem_waddr,
  input  logic [31:0]                   i_imem_wdata,
  input  logic                          i_redir_valid,
  input  logic [31:0]                   i_redir_pc,
  fetch_if.master                       o_dec,
  output logic [$clog2(DEPTH):0]        o_q_count,
  output logic [31:0]                   o_pop_count
);

  localparam int AW = $clog2(IMEM_WORDS);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]   r_imem    [IMEM_WORDS];
  logic [31:0]   r_q_instr [DEPTH];
  logic [31:0]   r_q_pc    [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pop_count;

  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic [31:0] w_fetch_word;
  logic [31:0] w_redir_word;
  logic [31:0] w_head_instr;
  logic [31:0] w_head_pc;

  // Asynchronous reads: a same-cycle write to the fetched address is only
  // visible after the edge, so the fetch sees the old word.
  assign w_valid      = (r_count != '0);
  assign w_fetch_word = r_imem[r_fetch_pc[AW-1:0]];
  assign w_redir_word = r_imem[i_redir_pc[AW-1:0]];

  // Redirect overrides both queue operations; a handshake in that cycle is
  // discarded and not counted.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_pop  = 1'b0;
    w_push = 1'b0;
    if (!i_redir_valid) begin
      w_pop  = w_valid && o_dec.ready;
      // A pop frees a slot in the same edge, so a full queue still refills.
      w_push = (r_count < FULL) || w_pop;
    end
  end

  // Program memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the memory is cleared by reset because the program must read
      // as all-zero after reset; this forces a flop array rather than RAM.
      for (int i = 0; i < IMEM_WORDS; i++) r_imem[i] <= '0;
    end else if (i_imem_we) begin
      r_imem[i_imem_waddr] <= i_imem_wdata;
    end
  end

  // Queue payload: not reset, entries are only observed through r_count.
  always_ff @(posedge clk) begin
    if (i_redir_valid) begin
      r_q_instr[0] <= w_redir_word;
      r_q_pc[0]    <= i_redir_pc;
    end else if (w_push) begin
      r_q_instr[r_wr_ptr] <= w_fetch_word;
      r_q_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  // Pointers, occupancy, fetch PC and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_fetch_pc  <= '0;
      r_pop_count <= '0;
    end else if (i_redir_valid) begin
      // Flush and place the target in slot 0 so it is the head next cycle.
      r_rd_ptr   <= '0;
      r_wr_ptr   <= PW'(1);
      r_count    <= (PW+1)'(1);
      r_fetch_pc <= i_redir_pc + 32'd1;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PW'(1);
        r_fetch_pc <= r_fetch_pc + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PW'(1);
        r_pop_count <= r_pop_count + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation; an empty queue drives zeros.
  assign w_head_instr = w_valid ? r_q_instr[r_rd_ptr] : '0;
  assign w_head_pc    = w_valid ? r_q_pc[r_rd_ptr]    : '0;

  assign o_dec.valid   = w_valid;
  assign o_dec.instr   = w_head_instr;
  assign o_dec.op      = w_head_instr[7:0];
  assign o_dec.imm     = w_head_instr[31:8];
  assign o_dec.pc      = w_head_pc;
  assign o_dec.illegal = (w_head_instr[7:0] > 8'h03);

  assign o_q_count   = r_count;
  assign o_pop_count = r_pop_count;

endmodule

// File: doc/pipeline_fetch_queue.md
# pipeline_fetch_queue

Instruction fetch and prefetch-queue stage that sits directly upstream of the accumulator execute pipeline (ALU ops ADD/MUL/CLR). It owns the 32-word instruction memory and a sequential fetch PC, and prefetches instructions into a small FIFO. The queue head is presented to decode over a valid/ready handshake, so multiply stalls (`ready` low) back-pressure fetch instead of losing instructions. A redirect port flushes the queue and restarts fetch at a new PC.

## Interface
- `DEPTH`, 4: prefetch queue entries; power of two, 2..16.
- `IMEM_WORDS`, 32: instruction memory words; power of two; fetch address is `pc % IMEM_WORDS`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_we`  in  1  instruction memory write enable (program load).
- `imem_waddr`  in  log2(IMEM_WORDS)  write address.
- `imem_wdata`  in  32  write data: op in [7:0], imm in [31:8].
- `redir_valid`  in  1  flush the queue and restart fetch at `redir_pc`.
- `redir_pc`  in  32  redirect target PC.
- `out_ready`  in  1  decode can accept an instruction; tied to the execute stage's `!mult`.
- `out_valid`  out  1  the queue head is valid.
- `out_instr`  out  32  head instruction word.
- `out_op`  out  8  `out_instr[7:0]`.
- `out_imm`  out  24  `out_instr[31:8]`.
- `out_pc`  out  32  PC of the head instruction (unwrapped, not modulo).
- `out_illegal`  out  1  head op > 8'h3. Op 0 is legal and means "write old value".
- `q_count`  out  log2(DEPTH)+1  current queue occupancy.
- `pop_count`  out  32  number of handshakes completed since reset; wraps modulo 2^32.

## Operation
- Memory
  - `IMEM_WORDS` x 32 array, all words cleared to 0 on reset.
  - Write on `imem_we` at the clock edge.
  - Fetch reads combinationally from `fetch_pc % IMEM_WORDS`.
  - When a fetch and a write hit the same address in the same cycle, the fetch gets the old data.
- Queue
  - Circular FIFO with read/write pointers and `q_count`.
  - `pop = out_valid && out_ready`.
  - `push = (q_count < DEPTH || pop) && !redir_valid`.
  - On push: enqueue {Imem[fetch_pc % IMEM_WORDS], fetch_pc}, then `fetch_pc <= fetch_pc + 1` (32-bit wrap).
  - On pop: advance the read pointer and increment `pop_count`.
  - Push and pop in the same cycle: `q_count` is unchanged. When full, this is how the queue refills.
- Outputs
  - `out_*` come combinationally from the head entry.
  - `out_valid = (q_count != 0)`.
  - When empty, `out_instr`, `out_pc` and `out_illegal` drive 0.
- Redirect (`redir_valid`=1 at an edge)
  - The queue is flushed.
  - One entry {Imem[redir_pc % IMEM_WORDS], redir_pc} is written.
  - `fetch_pc <= redir_pc + 1`.
  - `q_count <= 1`.
  - Redirect has priority over push and pop. A handshake in the redirect cycle is not counted and the head is discarded; decode must ignore it.
- Reset (asynchronous, any time, including mid-stall or mid-redirect)
  - `fetch_pc=0`, pointers=0, `q_count=0`, `pop_count=0`, memory=0.
  - Consequently all outputs are 0 and `out_valid=0`.

## Timing
- Fetch latency from reset release: the first edge pushes PC 0, so `out_valid`=1 after 1 edge.
- Sustained throughput is 1 instruction/cycle while `out_ready`=1. The queue holds at occupancy 1 in steady state.
- While `out_ready`=0, the queue fills by one per edge until `q_count=DEPTH`, then `fetch_pc` freezes.
- When `out_ready` rises, the first pop happens in that same cycle (zero-cycle release).
- Redirect latency: the target is at the head after 1 edge with `out_valid`=1. No bubble.
- `out_illegal` is purely combinational from the head op. It does not gate the handshake.

## Test plan
- Load Imem[0..3] = {0x000005_01, 0x000003_02, 0x000000_03, 0x000002_01}, reset, `out_ready`=1 -> `out_pc` is 0,1,2,3 on consecutive cycles, `out_op` is 01,02,03,01, and `pop_count`=4 after 4 pops.
- Hold `out_ready`=0 for 10 cycles after reset -> `q_count` climbs to 4 and stays there, `fetch_pc`=4, `out_pc`=0. When `out_ready`=1, PCs 0..7 appear back-to-back with no gaps.
- Full queue with `out_ready` pulsed 1 for one cycle -> exactly one pop, one push in the same edge, `q_count` stays 4, and the head becomes PC 1.
- Redirect with `redir_pc`=0x22 and `out_ready`=1 in the same cycle -> next cycle `q_count`=1, `out_pc`=0x22, `out_instr`=Imem[2]. `pop_count` is not incremented for the redirect cycle.
- Write Imem[5]=0x0000_00FF while fetching PC 5 -> the old word is fetched. After wrap to PC 37, 0xFF is fetched and `out_illegal`=1.
- Assert `rst_n`=0 mid-stall with the queue full -> all outputs are 0 immediately (asynchronous). After release, PC 0 reads instruction 0x0 (memory cleared).
